// File: rtl/cv_pkg.sv
// Shared definitions for the convolution datapath: default widths, weight-row
// budget per output pixel and the feature-map read sequencer state encoding.
package cv_pkg;

  localparam int ADR_W    = 16;
  localparam int DIM_W    = 10;
  localparam int CT_W     = 8;
  localparam int MAX_ROWS = 2048;

  // Row address width of the weights handler, sized to cover MAX_ROWS rows.
  localparam int WH_ADR_W = $clog2(MAX_ROWS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_END,
    ST_DONE
  } rd_state_e;

endpackage

// File: rtl/cv_fm_adr_gen.sv
// Nested ct/kx/ky/ox/oy counters with incremental feature-map address
// generation. adr is registered and always reflects the current position.
module cv_fm_adr_gen #(
  parameter int ADR_W = cv_pkg::ADR_W,
  parameter int DIM_W = cv_pkg::DIM_W,
  parameter int CT_W  = cv_pkg::CT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             step,
  input  logic [ADR_W-1:0] cfg_base,
  input  logic [DIM_W-1:0] cfg_in_w,
  input  logic [DIM_W-1:0] cfg_out_w,
  input  logic [DIM_W-1:0] cfg_out_h,
  input  logic [1:0]       cfg_k,
  input  logic             cfg_stride2,
  input  logic [CT_W-1:0]  cfg_ch_tiles,
  output logic             pix_last,
  output logic             layer_last,
  output logic [ADR_W-1:0] adr
);

  // Wide enough for (y*in_w + x)*ch_tiles plus base; truncated only at adr.
  localparam int IW = 2 * DIM_W + CT_W + 2;

  logic [CT_W-1:0]  ct, ct_max;
  logic [1:0]       kx, ky, k_max;
  logic [DIM_W-1:0] ox, oy, ow_max, oh_max;
  logic [IW-1:0]    row_stride, pix_stride, line_stride;
  logic [IW-1:0]    adr_r, row_base, pix_base, line_base;
  logic [IW-1:0]    row_next, pix_next, line_next;
  logic [IW-1:0]    base_ext, in_row;

  assign base_ext  = IW'(cfg_base);
  assign in_row    = IW'(cfg_in_w) * IW'(cfg_ch_tiles);
  assign row_next  = row_base + row_stride;
  assign pix_next  = pix_base + pix_stride;
  assign line_next = line_base + line_stride;

  assign pix_last   = (ct == ct_max) && (kx == k_max) && (ky == k_max);
  assign layer_last = pix_last && (ox == ow_max) && (oy == oh_max);
  assign adr        = adr_r[ADR_W-1:0];

  // Within one kernel row (kx, ct) the address simply counts up by one; only
  // ky, ox and oy carries need to rebase from the row/pixel/line anchors.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ct          <= '0;
      kx          <= '0;
      ky          <= '0;
      ox          <= '0;
      oy          <= '0;
      ct_max      <= '0;
      k_max       <= '0;
      ow_max      <= '0;
      oh_max      <= '0;
      row_stride  <= '0;
      pix_stride  <= '0;
      line_stride <= '0;
      adr_r       <= '0;
      row_base    <= '0;
      pix_base    <= '0;
      line_base   <= '0;
    end else if (clear) begin
      ct          <= '0;
      kx          <= '0;
      ky          <= '0;
      ox          <= '0;
      oy          <= '0;
      ct_max      <= cfg_ch_tiles - CT_W'(1);
      k_max       <= cfg_k - 2'd1;
      ow_max      <= cfg_out_w - DIM_W'(1);
      oh_max      <= cfg_out_h - DIM_W'(1);
      row_stride  <= in_row;
      pix_stride  <= IW'(cfg_ch_tiles) << cfg_stride2;
      line_stride <= in_row << cfg_stride2;
      adr_r       <= base_ext;
      row_base    <= base_ext;
      pix_base    <= base_ext;
      line_base   <= base_ext;
    end else if (step) begin
      if (ct != ct_max) begin
        ct    <= ct + CT_W'(1);
        adr_r <= adr_r + IW'(1);
      end else begin
        ct <= '0;
        if (kx != k_max) begin
          kx    <= kx + 2'd1;
          adr_r <= adr_r + IW'(1);
        end else begin
          kx <= '0;
          if (ky != k_max) begin
            ky       <= ky + 2'd1;
            row_base <= row_next;
            adr_r    <= row_next;
          end else begin
            ky <= '0;
            if (ox != ow_max) begin
              ox       <= ox + DIM_W'(1);
              pix_base <= pix_next;
              row_base <= pix_next;
              adr_r    <= pix_next;
            end else begin
              ox        <= '0;
              oy        <= (oy == oh_max) ? '0 : oy + DIM_W'(1);
              line_base <= line_next;
              pix_base  <= line_next;
              row_base  <= line_next;
              adr_r     <= line_next;
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/cv_fm_read_ctrl.sv
// Feature-map read sequencer: walks a layer's output pixels, issues buffer reads
// and re_fm_en/re_fm_end strobes. Define CV_FM_RD_STAT_EN for beat/hold counters.
module cv_fm_read_ctrl #(
  parameter int ADR_W    = cv_pkg::ADR_W,
  parameter int DIM_W    = cv_pkg::DIM_W,
  parameter int CT_W     = cv_pkg::CT_W,
  parameter int MAX_ROWS = cv_pkg::MAX_ROWS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [ADR_W-1:0] cfg_base,
  input  logic [DIM_W-1:0] cfg_in_w,
  input  logic [DIM_W-1:0] cfg_out_w,
  input  logic [DIM_W-1:0] cfg_out_h,
  input  logic [1:0]       cfg_k,
  input  logic             cfg_stride2,
  input  logic [CT_W-1:0]  cfg_ch_tiles,
  input  logic             hold,
  output logic             re_fm_en,
  output logic             re_fm_end,
  output logic             fm_rd_en,
  output logic [ADR_W-1:0] fm_adr,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
`ifdef CV_FM_RD_STAT_EN
  ,
  output logic [31:0]      stat_beats,
  output logic [31:0]      stat_hold
`endif
);

  import cv_pkg::*;

  rd_state_e       state, state_nxt;
  logic            step, clear, pix_last, layer_last;
  logic            re_en_d, re_end_d, rd_en_d, done_d, err_d;
  logic            cfg_ok;
  logic [3:0]      k_sq;
  logic [CT_W+3:0] rows_req;

  assign k_sq     = (cfg_k == 2'd3) ? 4'd9 : 4'd1;
  assign rows_req = (CT_W+4)'(k_sq) * (CT_W+4)'(cfg_ch_tiles);
  assign cfg_ok   = ((cfg_k == 2'd1) || (cfg_k == 2'd3)) &&
                    (cfg_in_w != '0) && (cfg_out_w != '0) && (cfg_out_h != '0) &&
                    (cfg_ch_tiles != '0) && (32'(rows_req) <= 32'(MAX_ROWS));

  cv_fm_adr_gen #(
    .ADR_W (ADR_W),
    .DIM_W (DIM_W),
    .CT_W  (CT_W)
  ) u_adr_gen (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .step         (step),
    .cfg_base     (cfg_base),
    .cfg_in_w     (cfg_in_w),
    .cfg_out_w    (cfg_out_w),
    .cfg_out_h    (cfg_out_h),
    .cfg_k        (cfg_k),
    .cfg_stride2  (cfg_stride2),
    .cfg_ch_tiles (cfg_ch_tiles),
    .pix_last     (pix_last),
    .layer_last   (layer_last),
    .adr          (fm_adr)
  );

  // NOTE: state and registered outputs use non-blocking assignments so every
  // flop samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      re_fm_en  <= 1'b0;
      re_fm_end <= 1'b0;
      fm_rd_en  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      re_fm_en  <= re_en_d;
      re_fm_end <= re_end_d;
      fm_rd_en  <= rd_en_d;
      busy      <= (state_nxt != ST_IDLE);
      done      <= done_d;
      cfg_err   <= err_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (start && cfg_ok) state_nxt = ST_RUN;
      ST_RUN:  if (!hold && pix_last) state_nxt = ST_END;
      ST_END:  if (!hold) state_nxt = layer_last ? ST_DONE : ST_RUN;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The state register names the cycle now visible on the outputs; these are
  // the values for the following cycle, so a beat shows one edge after start.
  always_comb begin
    step     = 1'b0;
    clear    = 1'b0;
    re_en_d  = 1'b0;
    re_end_d = 1'b0;
    rd_en_d  = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            clear   = 1'b1;
            re_en_d = 1'b1;
            rd_en_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (!hold) begin
          re_en_d = 1'b1;
          if (pix_last) begin
            re_end_d = 1'b1;
          end else begin
            step    = 1'b1;
            rd_en_d = 1'b1;
          end
        end
      end
      ST_END: begin
        if (!hold) begin
          if (layer_last) begin
            done_d = 1'b1;
          end else begin
            step    = 1'b1;
            re_en_d = 1'b1;
            rd_en_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

`ifdef CV_FM_RD_STAT_EN
  // A start seen in IDLE clears both counters and counts its own first beat.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_beats <= '0;
      stat_hold  <= '0;
    end else if (state == ST_IDLE && start) begin
      stat_beats <= {31'b0, rd_en_d};
      stat_hold  <= '0;
    end else begin
      if (rd_en_d && (stat_beats != '1)) stat_beats <= stat_beats + 32'd1;
      if ((state == ST_RUN || state == ST_END) && hold && (stat_hold != '1))
        stat_hold <= stat_hold + 32'd1;
    end
  end
`endif

endmodule

// File: doc/cv_fm_read_ctrl.md
# cv_fm_read_ctrl

Upstream sequencer for the convolution datapath. It walks one convolution layer's output pixels and generates per-beat feature-map buffer addresses. It also drives the `re_fm_en` / `re_fm_end` strobe pair that steps the weights handler's row address and wraps it back to 0 after each output pixel. One beat equals one feature-map row read plus one weight row read; both buffers have 1-cycle read latency, so their data arrives aligned.

## Interface
- `ADR_W`, 16, feature-map buffer address width
- `DIM_W`, 10, width of spatial dimension fields
- `CT_W`, 8, width of the channel-tile count field
- `MAX_ROWS`, 2048, weight rows per output pixel (weights handler address space)

Ports (clock and reset first):
- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-low (0 = reset)
- `start`  in  1  1-cycle pulse; latches cfg and begins the layer (ignored unless IDLE)
- `cfg_base`  in  ADR_W  feature-map base address
- `cfg_in_w`  in  DIM_W  input width, in pixels
- `cfg_out_w`, `cfg_out_h`  in  DIM_W  output width and height (≥1)
- `cfg_k`  in  2  kernel size; legal values are 1 and 3
- `cfg_stride2`  in  1  0 = stride 1, 1 = stride 2
- `cfg_ch_tiles`  in  CT_W  input channel tiles per pixel (≥1)
- `hold`  in  1  downstream backpressure; freezes sequencing
- `re_fm_en`  out  1  beat strobe to the weights handler
- `re_fm_end`  out  1  pixel-terminate strobe (asserted only with `re_fm_en`)
- `fm_rd_en`  out  1  feature-map buffer read enable
- `fm_adr`  out  ADR_W  feature-map buffer address
- `busy`  out  1  high outside IDLE
- `done`  out  1  1-cycle pulse at layer completion
- `cfg_err`  out  1  1-cycle pulse when `start` is rejected

## Operation
- States: IDLE, RUN, END, DONE.
- IDLE → RUN on `start` with legal config. Config is latched on that edge. Counters oy, ox, ky, kx, ct are cleared.
- Illegal config: `cfg_k` ∉ {1,3}, any zero dimension or zero tile count, or k·k·ch_tiles > MAX_ROWS. On illegal config, `cfg_err` pulses and the block stays in IDLE.
- RUN beat (when `hold`=0):
  - `re_fm_en`=1, `re_fm_end`=0, `fm_rd_en`=1.
  - `fm_adr` = base + ((oy·s+ky)·in_w + (ox·s+kx))·ch_tiles + ct, truncated mod 2^ADR_W.
- Loop order, innermost first: ct, kx, ky, ox, oy. After the beat where ct, kx and ky are all at their maximum, go to END.
- END (one cycle when `hold`=0):
  - `re_fm_en`=1, `re_fm_end`=1, `fm_rd_en`=0.
  - The weights handler wraps its address to 0 and performs no read.
  - Advance ox; on ox wrap, advance oy.
  - Return to RUN, or go to DONE if the terminated pixel was (out_w-1, out_h-1).
- DONE: `done`=1 for one cycle, then IDLE.
- `hold`=1 in RUN or END: `re_fm_en`, `re_fm_end` and `fm_rd_en` are all 0; counters and state are frozen; `fm_adr` holds.
- `start` while busy is ignored. Config inputs are don't-care after latch.
- Intermediate address arithmetic uses ≥ 2·DIM_W+CT_W bits, truncated only at output.

## Timing
- Reset values:
  - `re_fm_en`, `re_fm_end`, `fm_rd_en`, `busy`, `done`, `cfg_err` = 0
  - `fm_adr` = 0
  - state = IDLE
  - all counters = 0
- All outputs are registered.
- The first beat appears in the cycle after `start` is sampled.
- Beats per pixel = k²·ch_tiles, plus 1 END cycle.
- Total layer cycles with no hold = out_w·out_h·(k²·ch_tiles+1) + 1 (DONE).
- `busy` rises the cycle after `start` and falls the cycle after DONE.
- Synchronous `reset`=0 mid-layer: next edge returns all outputs to reset values. No `done` is generated and no END strobe is issued. The weights handler is reset by the same domain.
- `hold` takes effect in the same cycle it is sampled: outputs are deasserted on the next edge.

## Configuration
- `CV_FM_RD_STAT_EN`
  - Defined: adds output `stat_beats` (32 bits), counting RUN beats issued, and `stat_hold` (32 bits), counting held cycles while busy. Both clear on `start` and on reset, and saturate at all-ones.
  - Undefined: neither port nor its logic exists.

## Structure
- Shared package `cv_pkg`: state enum, default widths (ADR_W, DIM_W, CT_W), MAX_ROWS. The weights handler's 11-bit address derives from MAX_ROWS.
- One sub-module: `cv_fm_adr_gen`. It contains the nested counters and incremental address computation, exposing `step`, `clear`, `pix_last`, `layer_last` and `adr`. The FSM stays in `cv_fm_read_ctrl`.

## Test plan
- k=1, stride1, in_w=4, out 2×1, ch_tiles=2, base=0x100:
  - `fm_adr` sequence 0x100, 0x101, END, 0x102, 0x103, END, then `done`.
  - Total 7 cycles.
- k=3, stride2, in_w=5, out 2×2, ch_tiles=1:
  - Pixel (1,0) first address = base+2.
  - Pixel (0,1) first address = base+10.
  - Each pixel has 9 beats, then 1 END with `re_fm_end`=1.
- `hold` held high for 3 cycles mid-pixel:
  - Strobes go low, `fm_adr` frozen.
  - Sequence resumes at the exact next address; total cycles +3.
- k=3, ch_tiles=228 (2052 rows > 2048):
  - `cfg_err` pulses, `busy` stays 0, no strobes.
  - A subsequent legal `start` runs normally.
- `reset`=0 during beat 5 of a pixel:
  - Next edge: all outputs 0, state IDLE.
  - A new `start` restarts from base with `re_fm_end` never issued for the aborted pixel.
- `CV_FM_RD_STAT_EN` build, k=1, out 3×1, ch_tiles=4, 2 hold cycles:
  - `stat_beats`=12, `stat_hold`=2.
